// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states,
// and the alignment check.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_RESP,
        S_ERR
    } lsu_state_t;

    // Size 11 is never legal; halfwords need even addresses and words need word alignment.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: is_bad_access = 1'b0;
            SZ_HALF: is_bad_access = offset[0];
            SZ_WORD: is_bad_access = (offset != 2'b00);
            default: is_bad_access = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/halfword lane logic: load extraction with sign/zero extension, and
// read-modify-write merge of store data into a memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{offset, 3'b000} +: 8];
        half_sel  = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        merged    = rdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data = rdata;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-word data-memory interface with sub-word
// read-modify-write stores and sign/zero-extended loads.
//
// state | meaning
// IDLE  | ready; accepts a request and captures its fields
// RD    | MemRead strobe for one cycle
// MERGE | readData valid; sub-word store data merged into the read word
// WR    | MemWrite strobe for one cycle with the final word
// RESP  | loads: first cycle samples readData, second pulses resp_valid; stores: pulse
// ERR   | misaligned or illegal size; resp_valid with resp_err
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic        rd_wait_q;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    lsu_lane u_lane (
        .size        (size_q),
        .is_unsigned (uns_q),
        .offset      (addr_q[1:0]),
        .rdata       (readData),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = we_q ? S_MERGE : S_RESP;
            S_MERGE: state_d = S_WR;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = rd_wait_q ? S_RESP : S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wword_q   <= 32'h0;
            rdata_q   <= 32'h0;
            rd_wait_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wword_q   <= req_wdata;
                        rdata_q   <= 32'h0;
                        rd_wait_q <= 1'b0;
                    end
                end
                S_RD: begin
                    rd_wait_q <= ~we_q;
                end
                S_MERGE: begin
                    wword_q <= merged;
                end
                S_RESP: begin
                    if (rd_wait_q) begin
                        rdata_q   <= load_data;
                        rd_wait_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory-side outputs come only from registers so they cannot glitch with req_*.
    assign MemRead    = (state_q == S_RD);
    assign MemWrite   = (state_q == S_WR);
    assign address    = {addr_q[31:2], 2'b00};
    assign writeData  = wword_q;

    assign req_ready  = rst_n && (state_q == S_IDLE);
    assign resp_err   = (state_q == S_ERR);
    assign resp_valid = ((state_q == S_RESP) && !rd_wait_q) || (state_q == S_ERR);
    assign resp_rdata = ((state_q == S_RESP) && !rd_wait_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1-cycle registered data memory
// whose bytes start out as byte[a] = a[7:0].
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData = 32'h0;

    int total = 0;
    int bad = 0;
    int overlap = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData)
    );

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        end
    end

    always @(posedge clk) begin
        if (MemRead) readData <= mem[address[7:2]];
        if (MemWrite) mem[address[7:2]] <= writeData;
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and record an 8-cycle trace starting with the cycle after accept.
    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [7:0] mr, output logic [7:0] mw, output logic [7:0] rv,
                       output logic [31:0] rd, output logic err, output logic [31:0] a_seen,
                       output logic [31:0] w_seen);
        int waited;
        mr = 8'h0; mw = 8'h0; rv = 8'h0; rd = 32'hDEADDEAD; err = 1'bx;
        a_seen = 32'hDEADDEAD; w_seen = 32'hDEADDEAD;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFD; req_wdata = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mr[k] = MemRead;
            mw[k] = MemWrite;
            rv[k] = resp_valid;
            if (MemRead || MemWrite) a_seen = address;
            if (MemWrite) w_seen = writeData;
            if (resp_valid) begin
                rd = resp_rdata;
                err = resp_err;
            end
        end
    endtask

    logic [7:0]  mr, mw, rv;
    logic [31:0] rd, a_seen, w_seen;
    logic        err;
    int          acc, rsp;

    initial begin
        // Reset: every output low, including req_ready.
        repeat (2) @(negedge clk);
        chk("reset_outputs", {31'h0, |{req_ready, resp_valid, resp_rdata, resp_err,
                                       MemRead, MemWrite, address, writeData}}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Load word 0x10.
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lw_memread", {24'h0, mr}, 32'h01);
        chk("lw_memwrite", {24'h0, mw}, 32'h00);
        chk("lw_resp_timing", {24'h0, rv}, 32'h04);
        chk("lw_address", a_seen, 32'h10);
        chk("lw_rdata", rd, 32'h1312_1110);
        chk("lw_err", {31'h0, err}, 32'h0);

        // Byte loads at 0x80, signed then unsigned.
        run(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lb_signed", rd, 32'hFFFF_FF80);
        chk("lb_resp_timing", {24'h0, rv}, 32'h04);
        run(1'b0, 2'b00, 1'b1, 32'h80, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lbu", rd, 32'h0000_0080);

        // Halfword store 0xBEEF at 0x22: read-modify-write of word 0x20.
        run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("sh_memread", {24'h0, mr}, 32'h01);
        chk("sh_memwrite", {24'h0, mw}, 32'h04);
        chk("sh_resp_timing", {24'h0, rv}, 32'h08);
        chk("sh_write_addr", a_seen, 32'h20);
        chk("sh_write_data", w_seen, 32'hBEEF_2120);
        chk("sh_rdata_zero", rd, 32'h0);
        chk("sh_err", {31'h0, err}, 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lw_after_sh", rd, 32'hBEEF_2120);
        run(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lh_signed", rd, 32'hFFFF_BEEF);
        run(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lhu", rd, 32'h0000_BEEF);
        run(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lb_lane3", rd, 32'hFFFF_FFBE);

        // Word store then byte store into the same word.
        run(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE_F00D, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("sw_memread", {24'h0, mr}, 32'h00);
        chk("sw_memwrite", {24'h0, mw}, 32'h01);
        chk("sw_resp_timing", {24'h0, rv}, 32'h02);
        chk("sw_write_data", w_seen, 32'hCAFE_F00D);
        run(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00A5, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("sb_write_data", w_seen, 32'hCAFE_A50D);
        run(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("lw_after_sb", rd, 32'hCAFE_A50D);

        // Error cases: response in the first cycle, no memory strobes.
        run(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("mis_word_resp", {24'h0, rv}, 32'h01);
        chk("mis_word_err", {31'h0, err}, 32'h1);
        chk("mis_word_strobes", {16'h0, mr, mw}, 32'h0);
        chk("mis_word_rdata", rd, 32'h0);
        run(1'b1, 2'b11, 1'b0, 32'h08, 32'hFFFF_FFFF, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("size11_resp", {24'h0, rv}, 32'h01);
        chk("size11_err", {31'h0, err}, 32'h1);
        chk("size11_strobes", {16'h0, mr, mw}, 32'h0);
        run(1'b1, 2'b01, 1'b0, 32'h01, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("mis_half_err", {31'h0, err}, 32'h1);
        chk("mis_half_strobes", {16'h0, mr, mw}, 32'h0);

        // Reset during WR of a byte store to 0x41.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_wr", {31'h0, MemWrite}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_memwrite_drop", {30'h0, MemWrite, MemRead}, 32'h0);
        chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("abort_ready_low", {31'h0, req_ready}, 32'h0);
        repeat (2) @(negedge clk);
        chk("abort_still_quiet", {30'h0, resp_valid, MemWrite}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_release", {31'h0, req_ready}, 32'h1);
        chk("abort_mem_model", mem[16], 32'h4342_4140);
        run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mr, mw, rv, rd, err, a_seen, w_seen);
        chk("abort_mem_unchanged", rd, 32'h4342_4140);

        // Back-to-back loads with req_valid held high: 4-cycle turnaround.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        acc = 0; rsp = 0;
        for (int i = 0; i < 16; i++) begin
            if (req_ready) begin
                acc++;
                chk("b2b_idle_quiet", {29'h0, MemRead, MemWrite, resp_valid}, 32'h0);
            end
            if (resp_valid) begin
                rsp++;
                chk("b2b_rdata", resp_rdata, 32'h1312_1110);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", acc, 32'd4);
        chk("b2b_responses", rsp, 32'd4);
        chk("no_strobe_overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
